// File: rtl/snake_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snake_pkg : game-state codes, food FSM encoding and LFSR taps              |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package snake_pkg;

    localparam logic [1:0] GS_PLAY  = 2'b00;
    localparam logic [1:0] GS_PAUSE = 2'b01;
    localparam logic [1:0] GS_OVER  = 2'b10;
    localparam logic [1:0] GS_START = 2'b11;

    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_PLACE = 2'd1,
        FC_CHECK = 2'd2,
        FC_ARMED = 2'd3
    } fc_state_t;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & c_lfsr_taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/food_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | food_lfsr : free-running 16-bit Fibonacci LFSR, seeded on reset            |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module food_lfsr
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/food_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | food_ctrl : places food from an LFSR, detects eats, pulses get_food        |
// | Option    : FOOD_AVOID_BODY_EN adds a body-occupancy query before arming   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module food_ctrl
    import snake_pkg::*;
#(
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 24,
    parameter int          XW        = 5,
    parameter int          YW        = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 8,
    parameter int          INIT_FX   = 20,
    parameter int          INIT_FY   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    game_state,
    input  logic          move_tick,
    input  logic [XW-1:0] head_x,
    input  logic [YW-1:0] head_y,
    output logic [XW-1:0] food_x,
    output logic [YW-1:0] food_y,
    output logic          food_valid,
    output logic          get_food,
    output logic          occ_req,
    output logic [XW-1:0] occ_x,
    output logic [YW-1:0] occ_y,
    input  logic          occ_ack,
    input  logic          occ_hit
);

    localparam int            c_tw        = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [c_tw-1:0] c_max_tries = c_tw'(MAX_TRIES);
    localparam logic [XW:0]   c_grid_w    = (XW+1)'(GRID_W);
    localparam logic [YW:0]   c_grid_h    = (YW+1)'(GRID_H);
    localparam logic [XW-1:0] c_init_fx   = XW'(INIT_FX);
    localparam logic [YW-1:0] c_init_fy   = YW'(INIT_FY);

    logic [15:0]     w_lfsr;
    logic [XW-1:0]   w_cx;
    logic [YW-1:0]   w_cy;
    logic            w_x_over;
    logic            w_y_over;
    logic            w_in_range;
    logic            w_last_try;
    logic [XW-1:0]   w_fx;
    logic [YW-1:0]   w_fy;
    logic            w_head_hit;
    logic            w_unused;

    fc_state_t       r_state;
    logic [XW-1:0]   r_food_x;
    logic [YW-1:0]   r_food_y;
    logic            r_food_valid;
    logic            r_get_food;
    logic [c_tw-1:0] r_tries;

    food_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (w_lfsr)
    );

    assign w_cx       = w_lfsr[XW-1:0];
    assign w_cy       = w_lfsr[XW+YW-1:XW];
    assign w_x_over   = ({1'b0, w_cx} >= c_grid_w);
    assign w_y_over   = ({1'b0, w_cy} >= c_grid_h);
    assign w_in_range = !w_x_over && !w_y_over;
    assign w_last_try = (r_tries == c_max_tries);
    // The grid is at least half the coordinate range, so one subtract folds any candidate in.
    assign w_fx       = w_x_over ? (w_cx - c_grid_w[XW-1:0]) : w_cx;
    assign w_fy       = w_y_over ? (w_cy - c_grid_h[YW-1:0]) : w_cy;
    assign w_head_hit = (head_x == r_food_x) && (head_y == r_food_y);

`ifdef FOOD_AVOID_BODY_EN
    logic            r_occ_req;
    logic [XW-1:0]   r_occ_x;
    logic [YW-1:0]   r_occ_y;

    assign occ_req  = r_occ_req;
    assign occ_x    = r_occ_x;
    assign occ_y    = r_occ_y;
    assign w_unused = ^w_lfsr[15:XW+YW];
`else
    assign occ_req  = 1'b0;
    assign occ_x    = '0;
    assign occ_y    = '0;
    assign w_unused = ^{w_lfsr[15:XW+YW], occ_ack, occ_hit};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= FC_IDLE;
            r_food_x     <= c_init_fx;
            r_food_y     <= c_init_fy;
            r_food_valid <= 1'b0;
            r_get_food   <= 1'b0;
            r_tries      <= '0;
`ifdef FOOD_AVOID_BODY_EN
            r_occ_req    <= 1'b0;
            r_occ_x      <= '0;
            r_occ_y      <= '0;
`endif
        end else begin
            r_get_food <= 1'b0;
            if (game_state == GS_START) begin
                r_state      <= FC_IDLE;
                r_food_valid <= 1'b0;
                r_tries      <= '0;
`ifdef FOOD_AVOID_BODY_EN
                r_occ_req    <= 1'b0;
`endif
            end else if (game_state != GS_OVER) begin
                case (r_state)
                    FC_IDLE: begin
                        r_food_valid <= 1'b0;
                        if (game_state == GS_PLAY) begin
                            r_state <= FC_PLACE;
                        end
                    end
                    FC_PLACE: begin
                        if (w_in_range || w_last_try) begin
                            r_food_x <= w_fx;
                            r_food_y <= w_fy;
`ifdef FOOD_AVOID_BODY_EN
                            // The fallback candidate is taken without a body query.
                            if (w_last_try) begin
                                r_state      <= FC_ARMED;
                                r_food_valid <= 1'b1;
                            end else begin
                                r_state   <= FC_CHECK;
                                r_occ_req <= 1'b1;
                                r_occ_x   <= w_fx;
                                r_occ_y   <= w_fy;
                            end
`else
                            r_state      <= FC_ARMED;
                            r_food_valid <= 1'b1;
`endif
                        end else begin
                            r_tries <= r_tries + 1'b1;
                        end
                    end
                    FC_CHECK: begin
`ifdef FOOD_AVOID_BODY_EN
                        if (occ_ack) begin
                            r_occ_req <= 1'b0;
                            if (occ_hit) begin
                                r_tries <= r_tries + 1'b1;
                                r_state <= FC_PLACE;
                            end else begin
                                r_state      <= FC_ARMED;
                                r_food_valid <= 1'b1;
                            end
                        end
`else
                        r_state      <= FC_ARMED;
                        r_food_valid <= 1'b1;
`endif
                    end
                    FC_ARMED: begin
                        r_food_valid <= 1'b1;
                        if ((game_state == GS_PLAY) && move_tick && w_head_hit) begin
                            r_get_food   <= 1'b1;
                            r_food_valid <= 1'b0;
                            r_tries      <= '0;
                            r_state      <= FC_PLACE;
                        end
                    end
                    default: begin
                        r_state <= FC_IDLE;
                    end
                endcase
            end
        end
    end

    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_food_valid;
    assign get_food   = r_get_food;

endmodule
`default_nettype wire

// File: tb/tb_food_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_food_ctrl : directed self-checking bench for food_ctrl                  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_food_ctrl;
    import snake_pkg::*;

    localparam int GRID_W    = 32;
    localparam int GRID_H    = 24;
    localparam int MAX_TRIES = 8;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic [1:0] game_state = 2'b11;
    logic       move_tick  = 1'b0;
    logic [4:0] head_x     = '0;
    logic [4:0] head_y     = '0;
    logic       occ_ack    = 1'b0;
    logic       occ_hit    = 1'b0;
    logic [4:0] food_x, food_y, occ_x, occ_y;
    logic       food_valid, get_food, occ_req;

    int         n_vec = 0;
    int         n_err = 0;
    logic [15:0] m_lfsr;
    logic [4:0] e_x, e_y;

    food_ctrl #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(5), .YW(5), .LFSR_SEED(16'hACE1),
        .MAX_TRIES(MAX_TRIES), .INIT_FX(20), .INIT_FY(12)
    ) dut (
        .clk(clk), .rst(rst), .game_state(game_state), .move_tick(move_tick),
        .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
        .food_valid(food_valid), .get_food(get_food), .occ_req(occ_req),
        .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSR, stepped in lockstep with the design.
    always @(posedge clk) m_lfsr <= (!rst) ? 16'hACE1 : step(m_lfsr);

    // Food expected from a placement whose first PLACE cycle sees LFSR value l0.
    function automatic void predict(input logic [15:0] l0, output logic [4:0] px,
                                    output logic [4:0] py, output int cyc);
        logic [15:0] l;
        int cx, cy;
        l = l0; px = '0; py = '0; cyc = 0;
        for (int i = 0; i <= MAX_TRIES; i++) begin
            cx = int'(l[4:0]);
            cy = int'(l[9:5]);
            if (cx < GRID_W && cy < GRID_H) begin
                px = 5'(cx); py = 5'(cy); cyc = i + 1;
                return;
            end
            if (i == MAX_TRIES) begin
                px = 5'((cx >= GRID_W) ? cx - GRID_W : cx);
                py = 5'((cy >= GRID_H) ? cy - GRID_H : cy);
                cyc = i + 1;
                return;
            end
            l = step(l);
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic place_wait(input int hold, output int lat, output int k,
                              output logic [4:0] px, output logic [4:0] py,
                              output logic g1, output logic v1, output int n_get);
        lat = 0; k = 0; px = '0; py = '0; g1 = 1'b0; v1 = 1'b0; n_get = 0;
        do begin
            next_cycle();
            lat++;
            if (lat == 1) begin
                predict(m_lfsr, px, py, k);
                g1 = get_food;
                v1 = food_valid;
            end
            if (lat >= hold) move_tick = 1'b0;
            if (get_food === 1'b1) n_get++;
        end while (food_valid !== 1'b1 && lat < MAX_TRIES + 2);
    endtask

    task automatic test_reset();
        rst = 1'b0; game_state = GS_START;
        next_cycle(); next_cycle();
        n_vec++; if (food_x !== 5'd20) begin n_err++; $display("FAIL reset_food_x got %0d want 20", food_x); end
        n_vec++; if (food_y !== 5'd12) begin n_err++; $display("FAIL reset_food_y got %0d want 12", food_y); end
        n_vec++; if (food_valid !== 1'b0) begin n_err++; $display("FAIL reset_food_valid got %b want 0", food_valid); end
        n_vec++; if (get_food !== 1'b0) begin n_err++; $display("FAIL reset_get_food got %b want 0", get_food); end
        n_vec++; if (dut.w_lfsr !== 16'hACE1) begin n_err++; $display("FAIL reset_lfsr got %h want ace1", dut.w_lfsr); end
        n_vec++; if (occ_req !== 1'b0 || occ_x !== 5'd0 || occ_y !== 5'd0) begin
            n_err++; $display("FAIL reset_occ got req=%b x=%0d y=%0d want 0/0/0", occ_req, occ_x, occ_y); end
        rst = 1'b1;
        next_cycle();
        n_vec++; if (food_valid !== 1'b0) begin n_err++; $display("FAIL start_idle_valid got %b want 0", food_valid); end
    endtask

    task automatic test_first_place();
        int lat, k, n_get; logic [4:0] px, py; logic g1, v1;
        game_state = GS_PLAY;
        place_wait(0, lat, k, px, py, g1, v1, n_get);
        n_vec++; if (food_valid !== 1'b1 || lat != k + 1 || lat > MAX_TRIES + 2) begin
            n_err++; $display("FAIL first_place_latency got valid=%b lat=%0d want 1/%0d", food_valid, lat, k + 1); end
        n_vec++; if (food_x !== px || food_y !== py) begin
            n_err++; $display("FAIL first_place_pos got (%0d,%0d) want (%0d,%0d)", food_x, food_y, px, py); end
        e_x = px; e_y = py;
    endtask

    task automatic test_respawn();
        int lat, k, n_get; logic [4:0] px, py; logic g1, v1;
        for (int i = 0; i < 1000; i++) begin
            head_x = e_x; head_y = e_y; move_tick = 1'b1;
            place_wait(1, lat, k, px, py, g1, v1, n_get);
            n_vec++; if (g1 !== 1'b1 || v1 !== 1'b0) begin
                n_err++; $display("FAIL respawn_eat[%0d] got get=%b valid=%b want 1/0", i, g1, v1); end
            n_vec++; if (food_valid !== 1'b1 || lat != k + 1) begin
                n_err++; $display("FAIL respawn_latency[%0d] got valid=%b lat=%0d want 1/%0d", i, food_valid, lat, k + 1); end
            n_vec++; if (food_x !== px || food_y !== py) begin
                n_err++; $display("FAIL respawn_pos[%0d] got (%0d,%0d) want (%0d,%0d)", i, food_x, food_y, px, py); end
            n_vec++; if (int'(food_x) >= GRID_W || int'(food_y) >= GRID_H) begin
                n_err++; $display("FAIL respawn_range[%0d] got (%0d,%0d) want inside 32x24", i, food_x, food_y); end
            n_vec++; if (n_get != 1) begin
                n_err++; $display("FAIL respawn_pulses[%0d] got %0d want 1", i, n_get); end
            e_x = px; e_y = py;
        end
    endtask

    task automatic test_eat_fixed();
        int lat, k, n_get; logic [4:0] px, py; logic g1, v1; bit found;
        game_state = GS_START; found = 0;
        next_cycle();
        for (int c = 0; c < 20000 && !found; c++) begin
            predict(step(m_lfsr), px, py, k);
            if (px == 5'd5 && py == 5'd7) begin
                found = 1; game_state = GS_PLAY;
            end else begin
                next_cycle();
            end
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL eat57_search got none want a (5,7) start"); end
        place_wait(0, lat, k, px, py, g1, v1, n_get);
        n_vec++; if (food_valid !== 1'b1 || food_x !== 5'd5 || food_y !== 5'd7) begin
            n_err++; $display("FAIL eat57_armed got %b (%0d,%0d) want 1 (5,7)", food_valid, food_x, food_y); end
        head_x = 5'd5; head_y = 5'd8; move_tick = 1'b1;
        next_cycle(); move_tick = 1'b0;
        n_vec++; if (get_food !== 1'b0 || food_valid !== 1'b1) begin
            n_err++; $display("FAIL miss58 got get=%b valid=%b want 0/1", get_food, food_valid); end
        next_cycle();
        n_vec++; if (get_food !== 1'b0 || food_x !== 5'd5 || food_y !== 5'd7) begin
            n_err++; $display("FAIL miss58_hold got get=%b (%0d,%0d) want 0 (5,7)", get_food, food_x, food_y); end
        head_y = 5'd7; move_tick = 1'b1;
        place_wait(1, lat, k, px, py, g1, v1, n_get);
        n_vec++; if (g1 !== 1'b1 || v1 !== 1'b0 || n_get != 1) begin
            n_err++; $display("FAIL eat57_pulse got get=%b valid=%b n=%0d want 1/0/1", g1, v1, n_get); end
        n_vec++; if (food_valid !== 1'b1 || food_x !== px || food_y !== py) begin
            n_err++; $display("FAIL eat57_respawn got %b (%0d,%0d) want 1 (%0d,%0d)", food_valid, food_x, food_y, px, py); end
        e_x = px; e_y = py;
    endtask

    task automatic test_hold_tick();
        int lat, k, n_get, cur, want; logic [4:0] px, py, hx, hy; logic g1, v1;
        hx = e_x; hy = e_y;
        head_x = hx; head_y = hy; move_tick = 1'b1;
        place_wait(3, lat, k, px, py, g1, v1, n_get);
        cur = lat;
        for (int i = 0; i < 4; i++) begin
            next_cycle(); cur++;
            if (cur >= 3) move_tick = 1'b0;
            if (get_food === 1'b1) n_get++;
        end
        move_tick = 1'b0;
        // A second pulse is legal only if the new food lands on the head while ticks persist.
        want = 1 + ((k == 1 && px == hx && py == hy) ? 1 : 0);
        n_vec++; if (n_get != want) begin n_err++; $display("FAIL hold_tick_pulses got %0d want %0d", n_get, want); end
    endtask

    task automatic test_pause_over();
        int lat, k, n_get; logic [4:0] px, py; logic g1, v1;
        game_state = GS_START; next_cycle(); game_state = GS_PLAY;
        place_wait(0, lat, k, px, py, g1, v1, n_get);
        n_vec++; if (food_valid !== 1'b1 || food_x !== px || food_y !== py) begin
            n_err++; $display("FAIL rearm got %b (%0d,%0d) want 1 (%0d,%0d)", food_valid, food_x, food_y, px, py); end
        head_x = px; head_y = py; move_tick = 1'b1; game_state = GS_PAUSE;
        next_cycle(); next_cycle();
        n_vec++; if (get_food !== 1'b0 || food_valid !== 1'b1) begin
            n_err++; $display("FAIL pause_eat got get=%b valid=%b want 0/1", get_food, food_valid); end
        game_state = GS_OVER;
        next_cycle(); next_cycle();
        n_vec++; if (get_food !== 1'b0 || food_valid !== 1'b1 || food_x !== px || food_y !== py) begin
            n_err++; $display("FAIL over_eat got get=%b valid=%b (%0d,%0d) want 0/1 (%0d,%0d)", get_food, food_valid, food_x, food_y, px, py); end
        game_state = GS_PLAY;
        place_wait(1, lat, k, px, py, g1, v1, n_get);
        n_vec++; if (g1 !== 1'b1 || n_get != 1) begin
            n_err++; $display("FAIL resume_eat got get=%b n=%0d want 1/1", g1, n_get); end
    endtask

    task automatic test_start_mid_place();
        int lat, k, n_get, n_valid; logic [4:0] px, py; logic g1, v1; bit found;
        game_state = GS_START; found = 0;
        next_cycle();
        for (int c = 0; c < 20000 && !found; c++) begin
            predict(step(m_lfsr), px, py, k);
            if (k >= 2) begin found = 1; game_state = GS_PLAY; end
            else next_cycle();
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL midplace_search got none want a multi-try start"); end
        next_cycle();
        game_state = GS_START;
        next_cycle();
        n_vec++; if (dut.r_state !== FC_IDLE || food_valid !== 1'b0 || occ_req !== 1'b0) begin
            n_err++; $display("FAIL start_abort got state=%0d valid=%b req=%b want 0/0/0", dut.r_state, food_valid, occ_req); end
        n_valid = 0;
        for (int i = 0; i < MAX_TRIES + 2; i++) begin
            next_cycle();
            if (food_valid !== 1'b0) n_valid++;
        end
        n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL start_hold_valid got %0d cycles want 0", n_valid); end
        game_state = GS_PLAY;
        place_wait(0, lat, k, px, py, g1, v1, n_get);
        n_vec++; if (food_valid !== 1'b1 || lat != k + 1 || food_x !== px || food_y !== py) begin
            n_err++; $display("FAIL restart_place got %b lat=%0d (%0d,%0d) want 1 lat=%0d (%0d,%0d)", food_valid, lat, food_x, food_y, k + 1, px, py); end
    endtask

`ifdef FOOD_AVOID_BODY_EN
    task automatic test_avoid_body(input int n_hit);
        int nq, age, n_unstable; logic [4:0] qx, qy; logic last_hit;
        game_state = GS_START; next_cycle(); game_state = GS_PLAY;
        nq = 0; age = 0; n_unstable = 0; qx = '0; qy = '0; last_hit = 1'b0;
        for (int c = 0; c < 400 && food_valid !== 1'b1; c++) begin
            next_cycle();
            occ_ack = 1'b0; occ_hit = 1'b0;
            if (occ_req === 1'b1) begin
                if (age == 0) begin qx = occ_x; qy = occ_y; end
                else if (occ_x !== qx || occ_y !== qy) n_unstable++;
                if (age == 1) begin
                    occ_ack = 1'b1; occ_hit = (nq < n_hit); last_hit = occ_hit; nq++;
                end
                age++;
            end else begin
                age = 0;
            end
        end
        occ_ack = 1'b0; occ_hit = 1'b0;
        n_vec++; if (food_valid !== 1'b1 || occ_req !== 1'b0) begin
            n_err++; $display("FAIL avoid_arm[%0d] got valid=%b req=%b want 1/0", n_hit, food_valid, occ_req); end
        n_vec++; if (n_unstable != 0) begin n_err++; $display("FAIL avoid_stable[%0d] got %0d changes want 0", n_hit, n_unstable); end
        n_vec++; if (nq > n_hit + 1 || nq > MAX_TRIES || nq < 1) begin
            n_err++; $display("FAIL avoid_queries[%0d] got %0d want 1..%0d", n_hit, nq, MAX_TRIES); end
        if (nq > n_hit) begin
            n_vec++; if (last_hit !== 1'b0 || food_x !== qx || food_y !== qy) begin
                n_err++; $display("FAIL avoid_pos[%0d] got (%0d,%0d) want (%0d,%0d)", n_hit, food_x, food_y, qx, qy); end
        end else begin
            n_vec++; if (last_hit !== 1'b1 || int'(food_x) >= GRID_W || int'(food_y) >= GRID_H) begin
                n_err++; $display("FAIL avoid_fallback[%0d] got hit=%b (%0d,%0d) want 1 in-grid", n_hit, last_hit, food_x, food_y); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef FOOD_AVOID_BODY_EN
        test_avoid_body(3);
        test_avoid_body(1000);
`else
        test_first_place();
        test_respawn();
        test_eat_fixed();
        test_hold_tick();
        test_pause_over();
        test_start_mid_place();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
